// File: rtl/fofb_dsp_readout_sequencer.sv
// Fast-orbit-feedback DSP readout sequencer: once per FA cycle, walks the gatherer's
// BPM readout address and streams the captured X/Y/S words as one AXI-Stream packet.
module fofb_dsp_readout_sequencer #(
  parameter int FOFB_INDEX_WIDTH  = 9,
  parameter int CYCLE_COUNT_WIDTH = 16
) (
  input  logic                         sysClk,
  input  logic                         sysReset,
  input  logic                         FAstrobe,
  input  logic                         readoutValid,
  input  logic [FOFB_INDEX_WIDTH:0]    bpmCount,
  output logic [FOFB_INDEX_WIDTH-1:0]  fofbDSPreadoutAddress,
  input  logic [31:0]                  fofbDSPreadoutX,
  input  logic [31:0]                  fofbDSPreadoutY,
  input  logic [31:0]                  fofbDSPreadoutS,
  output logic                         M_TVALID,
  input  logic                         M_TREADY,
  output logic                         M_TLAST,
  output logic [31:0]                  M_TDATA,
  output logic                         busy,
  output logic                         doneStrobe,
  output logic                         overrunStrobe,
  output logic [CYCLE_COUNT_WIDTH-1:0] lastFrameCycles
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_FETCH, ST_SEND} state_t;
  typedef enum logic [1:0] {BEAT_X, BEAT_Y, BEAT_S} beat_t;

  localparam logic [FOFB_INDEX_WIDTH:0]    MAX_COUNT = {1'b1, {FOFB_INDEX_WIDTH{1'b0}}};
  localparam logic [FOFB_INDEX_WIDTH:0]    CNT_ONE   = {{FOFB_INDEX_WIDTH{1'b0}}, 1'b1};
  localparam logic [FOFB_INDEX_WIDTH-1:0]  ADDR_ONE  = {{(FOFB_INDEX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CYCLE_COUNT_WIDTH-1:0] CYC_ONE   = {{(CYCLE_COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                         state_q;
  beat_t                          beat_q;
  logic [FOFB_INDEX_WIDTH-1:0]    addr_q;
  logic [FOFB_INDEX_WIDTH:0]      count_q;
  logic                           rv_q;
  logic                           fetch_q;
  logic [CYCLE_COUNT_WIDTH-1:0]   frame_cnt_q;
  logic [63:0]                    capture_q;
  logic                           tvalid_q;
  logic                           tlast_q;
  logic [31:0]                    tdata_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           overrun_q;
  logic [CYCLE_COUNT_WIDTH-1:0]   lfc_q;

  logic [FOFB_INDEX_WIDTH:0]      count_clamped;
  logic [CYCLE_COUNT_WIDTH-1:0]   frame_cnt_inc;
  logic                           start;
  logic                           last_bpm;
  logic                           active;
  logic                           fetch_exit;

  assign count_clamped = (bpmCount > MAX_COUNT) ? MAX_COUNT : bpmCount;
  assign start         = readoutValid & ~rv_q;
  assign last_bpm      = (({1'b0, addr_q} + CNT_ONE) == count_q);
  assign frame_cnt_inc = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + CYC_ONE;
  assign active        = (state_q == ST_FETCH) || (state_q == ST_SEND);
  assign fetch_exit    = (state_q == ST_FETCH) && fetch_q;

  // NOTE: the capture buffer is pure datapath and is always loaded before it is read,
  // so it stays out of reset and needs no reset fan-out.
  always_ff @(posedge sysClk) begin
    if (fetch_exit) begin
      capture_q <= {fofbDSPreadoutS, fofbDSPreadoutY};
    end
  end

  // NOTE: every register here uses non-blocking assignments so all branches see the
  // pre-edge values of state_q, beat_q and addr_q regardless of statement order.
  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_q     <= ST_IDLE;
      beat_q      <= BEAT_X;
      addr_q      <= '0;
      count_q     <= '0;
      rv_q        <= 1'b0;
      fetch_q     <= 1'b0;
      frame_cnt_q <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      lfc_q       <= '0;
    end else begin
      rv_q      <= readoutValid;
      done_q    <= 1'b0;
      overrun_q <= active & FAstrobe;
      if (active) begin
        frame_cnt_q <= frame_cnt_inc;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (FAstrobe && (count_clamped != '0)) begin
            state_q <= ST_ARMED;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            count_q <= count_clamped;
          end
        end
        ST_ARMED: begin
          if (start) begin
            state_q     <= ST_FETCH;
            frame_cnt_q <= '0;
            beat_q      <= BEAT_X;
            fetch_q     <= 1'b0;
          end
        end
        ST_FETCH: begin
          // Address has been stable for two cycles; the gatherer data is now valid.
          if (fetch_q) begin
            state_q  <= ST_SEND;
            beat_q   <= BEAT_X;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tdata_q  <= fofbDSPreadoutX;
          end else begin
            fetch_q <= 1'b1;
          end
        end
        ST_SEND: begin
          if (M_TREADY) begin
            case (beat_q)
              BEAT_X: begin
                beat_q  <= BEAT_Y;
                tdata_q <= capture_q[31:0];
              end
              BEAT_Y: begin
                beat_q  <= BEAT_S;
                tdata_q <= capture_q[63:32];
                tlast_q <= last_bpm;
              end
              default: begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                if (last_bpm) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  lfc_q   <= frame_cnt_inc;
                end else begin
                  state_q <= ST_FETCH;
                  fetch_q <= 1'b0;
                  addr_q  <= addr_q + ADDR_ONE;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign fofbDSPreadoutAddress = addr_q;
  assign M_TVALID              = tvalid_q;
  assign M_TLAST               = tlast_q;
  assign M_TDATA               = tdata_q;
  assign busy                  = busy_q;
  assign doneStrobe            = done_q;
  assign overrunStrobe         = overrun_q;
  assign lastFrameCycles       = lfc_q;

endmodule

// File: tb/tb_fofb_dsp_readout_sequencer.sv
// Bench for fofb_dsp_readout_sequencer: a frame-level reference model predicts the
// expected beat list, address, strobes and frame duration, checked every cycle.
module tb_fofb_dsp_readout_sequencer;

  localparam int IW = 9;
  localparam int CW = 16;

  logic          sysClk = 1'b0;
  logic          sysReset;
  logic          FAstrobe;
  logic          readoutValid;
  logic [IW:0]   bpmCount;
  logic [IW-1:0] fofbDSPreadoutAddress;
  logic [31:0]   gx, gy, gs;
  logic          M_TVALID, M_TREADY, M_TLAST;
  logic [31:0]   M_TDATA;
  logic          busy, doneStrobe, overrunStrobe;
  logic [CW-1:0] lastFrameCycles;
  logic [7:0]    salt;

  always #5 sysClk = ~sysClk;

  fofb_dsp_readout_sequencer #(.FOFB_INDEX_WIDTH(IW), .CYCLE_COUNT_WIDTH(CW)) dut (
    .sysClk(sysClk), .sysReset(sysReset), .FAstrobe(FAstrobe), .readoutValid(readoutValid),
    .bpmCount(bpmCount), .fofbDSPreadoutAddress(fofbDSPreadoutAddress),
    .fofbDSPreadoutX(gx), .fofbDSPreadoutY(gy), .fofbDSPreadoutS(gs),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TLAST(M_TLAST), .M_TDATA(M_TDATA),
    .busy(busy), .doneStrobe(doneStrobe), .overrunStrobe(overrunStrobe),
    .lastFrameCycles(lastFrameCycles)
  );

  // Word stored by the gatherer for BPM a: kind tag, per-frame salt, address.
  function automatic logic [31:0] pat(input int kind, input logic [IW-1:0] a, input logic [7:0] s);
    return {4'(kind + 1), 4'h0, s, 7'h0, a};
  endfunction

  // Gatherer model: registered lookup of the current address.
  always @(posedge sysClk) begin
    gx <= pat(0, fofbDSPreadoutAddress, salt);
    gy <= pat(1, fofbDSPreadoutAddress, salt);
    gs <= pat(2, fofbDSPreadoutAddress, salt);
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_ARMED, M_ACTIVE} mode_t;
  typedef struct { logic [31:0] data; bit last; int kind; } beat_t;

  mode_t         m_mode = M_IDLE;
  beat_t         beats[$];
  beat_t         b;
  int            gap = 0;
  int            m_cycles = 0;
  int            n_bpm;
  bit            rv_prev = 0, exp_done = 0, exp_over = 0, started = 0, exp_valid;
  logic [IW-1:0] exp_addr = '0;
  logic [CW-1:0] exp_lfc = '0;

  // observation counters used by the literal checks
  int beats_acc = 0, tlast_count = 0, tlast_pos = 0, last_beat_addr = -1;
  int stall_count = 0, done_count = 0, over_count = 0;
  int frame_b0 = 0, stalls_left = 0;

  always @(negedge sysClk) begin
    if (started) begin
      exp_valid = (m_mode == M_ACTIVE) && (gap == 0);
      check("busy", 32'(busy), 32'(m_mode != M_IDLE));
      check("doneStrobe", 32'(doneStrobe), 32'(exp_done));
      check("overrunStrobe", 32'(overrunStrobe), 32'(exp_over));
      check("address", 32'(fofbDSPreadoutAddress), 32'(exp_addr));
      check("lastFrameCycles", 32'(lastFrameCycles), 32'(exp_lfc));
      check("tvalid", 32'(M_TVALID), 32'(exp_valid));
      if (exp_valid && beats.size() > 0) begin
        check("tdata", M_TDATA, beats[0].data);
        check("tlast", 32'(M_TLAST), 32'(beats[0].last));
      end
      if (doneStrobe === 1'b1) done_count++;
      if (overrunStrobe === 1'b1) over_count++;
    end
    if (!sysReset && M_TVALID === 1'b1 && M_TREADY) begin
      beats_acc++;
      if (M_TLAST === 1'b1) begin
        tlast_count++;
        tlast_pos = beats_acc - frame_b0;
        last_beat_addr = int'(fofbDSPreadoutAddress);
      end
    end
    if (!sysReset && M_TVALID === 1'b1 && !M_TREADY) stall_count++;

    // predict the next cycle from the inputs the coming edge will sample
    exp_done = 0;
    exp_over = 0;
    if (sysReset) begin
      m_mode = M_IDLE; exp_addr = '0; exp_lfc = '0; rv_prev = 0; started = 1;
      beats.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (FAstrobe) begin
          n_bpm = (int'(bpmCount) > (1 << IW)) ? (1 << IW) : int'(bpmCount);
          if (n_bpm != 0) begin
            m_mode = M_ARMED;
            exp_addr = '0;
            beats.delete();
            for (int a = 0; a < n_bpm; a++)
              for (int k = 0; k < 3; k++) begin
                b.data = pat(k, IW'(a), salt);
                b.last = (a == n_bpm - 1) && (k == 2);
                b.kind = k;
                beats.push_back(b);
              end
          end
        end
        M_ARMED: if (readoutValid && !rv_prev) begin
          m_mode = M_ACTIVE; gap = 2; m_cycles = 0;
        end
        default: begin
          m_cycles = (m_cycles < 65535) ? m_cycles + 1 : 65535;
          if (FAstrobe) exp_over = 1;
          if (gap > 0) gap--;
          else if (M_TREADY) begin
            b = beats.pop_front();
            if (b.last) begin
              m_mode = M_IDLE; exp_done = 1; exp_lfc = CW'(m_cycles);
            end else if (b.kind == 2) begin
              gap = 2; exp_addr = exp_addr + 1'b1;
            end
          end
        end
      endcase
      rv_prev = readoutValid;
    end
  end

  // Ready driver: stalls only while data is offered; forces out any remaining stall
  // budget from the 7th beat on so the requested total is always reached.
  initial forever begin
    @(posedge sysClk); #1;
    if (stalls_left > 0 && M_TVALID === 1'b1 &&
        ($urandom_range(0, 1) == 1 || (beats_acc - frame_b0) >= 6)) begin
      M_TREADY = 1'b0;
      stalls_left--;
    end else begin
      M_TREADY = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge sysClk); #1; end
  endtask

  task automatic pulse_fa();
    FAstrobe = 1'b1; tick(1); FAstrobe = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_count;
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done_count != d0) begin ok = 1; break; end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_present(input int beat_no, input int budget, input string name);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (M_TVALID === 1'b1 && (beats_acc - frame_b0) == beat_no) begin ok = 1; break; end
      tick(1);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic run_frame(input logic [IW:0] cnt, input int stalls, input int budget);
    bpmCount = cnt; salt = 8'($urandom); tlast_pos = 0;
    tick(1);
    frame_b0 = beats_acc; stalls_left = stalls;
    pulse_fa();
    tick(2);
    readoutValid = 1'b1;
    wait_done(budget, "frame_done");
    readoutValid = 1'b0;
    tick(1);
  endtask

  int d0, o0, s0, b0;

  initial begin
    sysReset = 1'b1; FAstrobe = 1'b0; readoutValid = 1'b0; bpmCount = 10'd3;
    M_TREADY = 1'b1; salt = 8'h11;
    tick(3);
    sysReset = 1'b0;
    check("reset_tdata", M_TDATA, 32'd0);
    check("reset_tlast", 32'(M_TLAST), 32'd0);
    check("reset_tvalid", 32'(M_TVALID), 32'd0);
    check("reset_lfc", 32'(lastFrameCycles), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    tick(2);

    // basic frame, no backpressure
    d0 = done_count;
    run_frame(10'd3, 0, 100);
    check("t1_lfc", 32'(lastFrameCycles), 32'd15);
    check("t1_beats", beats_acc - frame_b0, 32'd9);
    check("t1_tlast_pos", tlast_pos, 32'd9);
    check("t1_done", done_count - d0, 32'd1);

    // same frame with 7 random stall cycles
    s0 = stall_count;
    run_frame(10'd3, 7, 200);
    check("t2_stalls", stall_count - s0, 32'd7);
    check("t2_lfc", 32'(lastFrameCycles), 32'd22);
    check("t2_beats", beats_acc - frame_b0, 32'd9);
    check("t2_tlast_pos", tlast_pos, 32'd9);

    // readoutValid already high across FAstrobe: only a later rising edge starts
    frame_b0 = beats_acc;
    readoutValid = 1'b1; tick(3);
    pulse_fa(); tick(5);
    check("t3_armed_busy", 32'(busy), 32'd1);
    check("t3_no_beats", beats_acc - frame_b0, 32'd0);
    readoutValid = 1'b0; tick(10);
    readoutValid = 1'b1;
    wait_done(100, "t3_done");
    readoutValid = 1'b0;
    check("t3_lfc", 32'(lastFrameCycles), 32'd15);
    check("t3_beats", beats_acc - frame_b0, 32'd9);

    // FAstrobe during SEND of BPM 1
    tick(2);
    frame_b0 = beats_acc; o0 = over_count; d0 = done_count;
    pulse_fa(); tick(2);
    readoutValid = 1'b1;
    wait_present(3, 50, "t4_x1_present");
    pulse_fa();
    wait_done(100, "t4_done");
    check("t4_overrun", over_count - o0, 32'd1);
    check("t4_beats", beats_acc - frame_b0, 32'd9);
    readoutValid = 1'b0; tick(2);
    readoutValid = 1'b1; tick(10);
    check("t4_edge_ignored", 32'(busy), 32'd0);
    check("t4_no_extra_done", done_count - d0, 32'd1);
    readoutValid = 1'b0; tick(2);

    // FAstrobe on the final accept (overrun), then again on the doneStrobe cycle (arms)
    frame_b0 = beats_acc; o0 = over_count; d0 = done_count;
    pulse_fa(); tick(2);
    readoutValid = 1'b1;
    wait_present(8, 50, "t4b_last_present");
    pulse_fa();
    readoutValid = 1'b0;
    check("t4b_done_pulse", 32'(doneStrobe), 32'd1);
    pulse_fa();
    check("t4b_overrun", over_count - o0, 32'd1);
    check("t4b_rearmed", 32'(busy), 32'd1);
    tick(2);
    readoutValid = 1'b1;
    wait_done(100, "t4b_second_done");
    readoutValid = 1'b0;
    check("t4b_beats", beats_acc - frame_b0, 32'd18);
    tick(2);

    // bpmCount = 0 never arms
    bpmCount = '0; d0 = done_count; b0 = beats_acc;
    pulse_fa(); tick(2);
    readoutValid = 1'b1; tick(20);
    check("t5_zero_busy", 32'(busy), 32'd0);
    check("t5_zero_done", done_count - d0, 32'd0);
    check("t5_zero_beats", beats_acc - b0, 32'd0);
    readoutValid = 1'b0; tick(2);

    // oversize count clamps to 512 BPMs
    run_frame(10'd517, 0, 3000);
    check("t5_clamp_lfc", 32'(lastFrameCycles), 32'd2560);
    check("t5_clamp_last_addr", last_beat_addr, 32'd511);
    check("t5_clamp_beats", beats_acc - frame_b0, 32'd1536);

    // reset while beat Y of BPM 1 is on the bus
    bpmCount = 10'd3; d0 = done_count;
    frame_b0 = beats_acc;
    pulse_fa(); tick(2);
    readoutValid = 1'b1;
    wait_present(4, 50, "t6_y1_present");
    sysReset = 1'b1; tick(1); sysReset = 1'b0; readoutValid = 1'b0;
    check("t6_tvalid", 32'(M_TVALID), 32'd0);
    check("t6_addr", 32'(fofbDSPreadoutAddress), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_tlast", 32'(M_TLAST), 32'd0);
    check("t6_no_done", done_count - d0, 32'd0);
    tick(2);
    run_frame(10'd3, 0, 100);
    check("t6_after_beats", beats_acc - frame_b0, 32'd9);
    check("t6_after_lfc", 32'(lastFrameCycles), 32'd15);
    check("t6_after_tlast_pos", tlast_pos, 32'd9);

    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fofb_dsp_readout_sequencer.md
Name: fofb_dsp_readout_sequencer

Overview:
- Downstream consumer of the fast-orbit-feedback link gatherer's DSP readout port.
- Once per FA cycle, after the gatherer flags its readout valid, walks BPM addresses 0..bpmCount-1 on the readout address bus and captures X/Y/S for each.
- Emits the captured values as one AXI-Stream packet (X, Y, S per BPM, TLAST on the final S) to the correction DSP.
- Holds each address stable and steps it by exactly +1, so the gatherer's "hold last value" store (written on address LSB toggle) sees every BPM.

Parameters:
- FOFB_INDEX_WIDTH, 9, width of BPM readout address.
- CYCLE_COUNT_WIDTH, 16, width of frame-duration counter.

Ports:
- sysClk  input  1  system clock.
- sysReset  input  1  synchronous, active-high reset.
- FAstrobe  input  1  single-cycle fast-acquisition strobe.
- readoutValid  input  1  level from gatherer; all cells received this FA cycle.
- bpmCount  input  FOFB_INDEX_WIDTH+1  BPMs per frame; values above 2^FOFB_INDEX_WIDTH are clamped to 2^FOFB_INDEX_WIDTH.
- fofbDSPreadoutAddress  output  FOFB_INDEX_WIDTH  readout address to gatherer.
- fofbDSPreadoutX / fofbDSPreadoutY / fofbDSPreadoutS  input  32 each  gatherer data; valid 2 cycles after the address changes.
- M_TVALID  output  1  stream valid.
- M_TREADY  input  1  stream ready.
- M_TLAST  output  1  last beat of frame.
- M_TDATA  output  32  beat data.
- busy  output  1  high in ARMED/FETCH/SEND.
- doneStrobe  output  1  one-cycle pulse after the final beat is accepted.
- overrunStrobe  output  1  one-cycle pulse when FAstrobe arrives during FETCH/SEND.
- lastFrameCycles  output  CYCLE_COUNT_WIDTH  duration of the last completed frame.

Behaviour:
- Reset values: state IDLE; address 0; M_TVALID 0; M_TLAST 0; M_TDATA 0; busy 0; strobes 0; lastFrameCycles 0; readoutValid_d 0.
- readoutValid_d is a registered copy of readoutValid. Start condition = readoutValid & ~readoutValid_d (rising edge only; a level that is already high never starts a frame).
- IDLE:
  - FAstrobe with clamped bpmCount != 0 -> ARMED; address <= 0.
  - FAstrobe with bpmCount == 0 -> stay IDLE; no beats, no doneStrobe.
- ARMED:
  - Start condition -> FETCH; frame counter <= 0; beat index <= 0.
  - FAstrobe while ARMED stays ARMED; this is not an overrun.
- FETCH: lasts exactly 2 cycles with the address held. On the exit edge, capture {S,Y,X} into a 96-bit buffer, then -> SEND.
- SEND:
  - M_TVALID = 1. M_TDATA = X, Y, then S, selected by beat index 0/1/2.
  - Beat index advances only on M_TVALID & M_TREADY. M_TDATA and M_TLAST stay stable while stalled.
  - M_TLAST = 1 only on beat 2 of address bpmCount-1.
  - On S-beat accept:
    - If last BPM: -> IDLE, doneStrobe = 1 next cycle, lastFrameCycles <= counter+1, address held.
    - Otherwise: address <= address+1, -> FETCH.
- Address changes only on FETCH entry from SEND (+1) or on IDLE->ARMED (reset to 0). No wrap within a frame.
- Frame counter: increments every cycle in FETCH/SEND; saturates at all-ones. Per-BPM cost with no stall = 5 cycles.
- Outputs are registered. M_TVALID rises on the cycle after FETCH exits.
- Simultaneous events:
  - FAstrobe in FETCH/SEND: overrunStrobe pulses 1 cycle; current frame completes unchanged; the strobe is dropped (not re-armed).
  - FAstrobe on the same cycle as the final-beat accept: counts as an overrun, ends in IDLE.
  - FAstrobe in IDLE on the same cycle as doneStrobe: arms normally.
- sysReset mid-frame: next cycle all outputs are at reset values. The packet is truncated without TLAST; the downstream consumer tolerates this.

Test Plan:
- bpmCount=3, TREADY=1, X/Y/S = addr-derived patterns; FAstrobe then readoutValid rises -> expect:
  - 9 beats X0,Y0,S0,X1,…,S2 with TLAST only on beat 9;
  - addresses 0,1,2, each held 5 cycles;
  - doneStrobe once; lastFrameCycles=15.
- Same frame with TREADY pseudo-random (~50% duty), 7 stall cycles total -> identical beat sequence; data stable during stalls; address never changes in SEND; lastFrameCycles=22.
- readoutValid already high across the FAstrobe -> no start; readoutValid drops then rises 10 cycles later -> frame starts on that edge.
- FAstrobe injected during SEND of BPM 1 (bpmCount=3) -> overrunStrobe single pulse; all 9 beats delivered; IDLE afterwards; next readoutValid edge ignored until a new FAstrobe.
- bpmCount=0 with FAstrobe and readoutValid edge -> busy stays 0; no TVALID; no doneStrobe. bpmCount=2^FOFB_INDEX_WIDTH+5 -> clamped, final address 2^FOFB_INDEX_WIDTH-1 with TLAST.
- sysReset asserted during beat Y of BPM 1 -> next cycle TVALID=0, address=0, busy=0; a fresh FAstrobe + valid edge yields a complete 9-beat frame.
